// File: rtl/spm_pkg.sv
// Shared definitions for the 8-bit stored-program machine.
// Used by the control unit, the datapath bus muxes and the ALU.
//   - state_t           : control-unit sequencing states
//   - OP_*              : opcode values in instruction[7:4]
//   - BUS1_* / BUS2_*   : bus mux select encodings
//   - *_MSB / *_LSB     : instruction field positions
package spm_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FET1,
    S_FET2,
    S_DEC,
    S_EX1,
    S_RD1,
    S_RD2,
    S_WR1,
    S_WR2,
    S_BR1,
    S_BR2,
    S_HALT
  } state_t;

  // Opcodes; 9..E are illegal and halt the machine.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_RD   = 4'h5;
  localparam logic [3:0] OP_WR   = 4'h6;
  localparam logic [3:0] OP_BR   = 4'h7;
  localparam logic [3:0] OP_BRZ  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Bus1 sources.
  localparam logic [2:0] BUS1_R0 = 3'd0;
  localparam logic [2:0] BUS1_R1 = 3'd1;
  localparam logic [2:0] BUS1_R2 = 3'd2;
  localparam logic [2:0] BUS1_R3 = 3'd3;
  localparam logic [2:0] BUS1_PC = 3'd4;

  // Bus2 sources.
  localparam logic [1:0] BUS2_ALU  = 2'd0;
  localparam logic [1:0] BUS2_BUS1 = 2'd1;
  localparam logic [1:0] BUS2_MEM  = 2'd2;

  // Instruction fields.
  localparam int OPCODE_MSB = 7;
  localparam int OPCODE_LSB = 4;
  localparam int SRC_MSB    = 3;
  localparam int SRC_LSB    = 2;
  localparam int DEST_MSB   = 1;
  localparam int DEST_LSB   = 0;

endpackage

// File: rtl/spm_control_unit.sv
// Instruction-sequencing control unit for the 8-bit stored-program machine.
// Walks FET1 -> FET2 -> DEC -> execute states for the instruction held in the
// instruction register and drives every datapath load, mux select and the
// memory write strobe. HALT or an illegal opcode parks it in S_HALT until reset.
//
// Ports:
//   clk              : clock, rising edge
//   rst              : asynchronous active-low reset (to S_IDLE, outputs 0)
//   instruction      : instruction register contents {opcode, src, dest}
//   zero             : Z flag, looked at only in S_DEC for BRZ
//   load_R0..load_R3 : general register loads (at most one, chosen by dest)
//   load_PC, inc_PC  : program counter load / increment
//   load_IR          : instruction register load
//   load_Add_R       : address register load
//   load_Reg_Y/Z     : ALU operand / result register loads
//   sel_bus_1_mux    : Bus1 source (BUS1_*)
//   sel_bus_2_mux    : Bus2 source (BUS2_*)
//   write            : memory write strobe
//   state            : current sequencing state, for observation
//
// Outputs are combinational decodes of state and instruction; they may glitch
// within a cycle and are settled before the next rising edge.
module spm_control_unit
  import spm_pkg::*;
#(
  parameter int word_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 zero,
  output logic                 load_R0,
  output logic                 load_R1,
  output logic                 load_R2,
  output logic                 load_R3,
  output logic                 load_PC,
  output logic                 inc_PC,
  output logic                 load_IR,
  output logic                 load_Add_R,
  output logic                 load_Reg_Y,
  output logic                 load_Reg_Z,
  output logic [2:0]           sel_bus_1_mux,
  output logic [1:0]           sel_bus_2_mux,
  output logic                 write,
  output state_t               state
);

  state_t     state_next;
  logic [3:0] load_r;
  logic [3:0] opcode;
  logic [1:0] src;
  logic [1:0] dest;

  assign opcode = instruction[OPCODE_MSB:OPCODE_LSB];
  assign src    = instruction[SRC_MSB:SRC_LSB];
  assign dest   = instruction[DEST_MSB:DEST_LSB];

  assign {load_R3, load_R2, load_R1, load_R0} = load_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next    = state;
    load_r        = 4'b0000;
    load_PC       = 1'b0;
    inc_PC        = 1'b0;
    load_IR       = 1'b0;
    load_Add_R    = 1'b0;
    load_Reg_Y    = 1'b0;
    load_Reg_Z    = 1'b0;
    sel_bus_1_mux = BUS1_R0;
    sel_bus_2_mux = BUS2_ALU;
    write         = 1'b0;

    case (state)
      S_IDLE: state_next = S_FET1;

      // Put the PC on the address register to fetch the instruction word.
      S_FET1: begin
        sel_bus_1_mux = BUS1_PC;
        sel_bus_2_mux = BUS2_BUS1;
        load_Add_R    = 1'b1;
        state_next    = S_FET2;
      end

      S_FET2: begin
        sel_bus_2_mux = BUS2_MEM;
        load_IR       = 1'b1;
        inc_PC        = 1'b1;
        state_next    = S_DEC;
      end

      S_DEC: begin
        case (opcode)
          OP_NOP: state_next = S_FET1;
          OP_ADD, OP_SUB, OP_AND: begin
            sel_bus_1_mux = {1'b0, src};
            load_Reg_Y    = 1'b1;
            state_next    = S_EX1;
          end
          // Single-operand op completes here: ALU result goes to Z and dest.
          OP_NOT: begin
            sel_bus_1_mux = {1'b0, src};
            sel_bus_2_mux = BUS2_ALU;
            load_Reg_Z    = 1'b1;
            load_r[dest]  = 1'b1;
            state_next    = S_FET1;
          end
          // Memory-class ops: point the address register at the operand word.
          OP_RD, OP_WR, OP_BR: begin
            sel_bus_1_mux = BUS1_PC;
            sel_bus_2_mux = BUS2_BUS1;
            load_Add_R    = 1'b1;
            if (opcode == OP_RD)      state_next = S_RD1;
            else if (opcode == OP_WR) state_next = S_WR1;
            else                      state_next = S_BR1;
          end
          OP_BRZ: begin
            if (zero) begin
              sel_bus_1_mux = BUS1_PC;
              sel_bus_2_mux = BUS2_BUS1;
              load_Add_R    = 1'b1;
              state_next    = S_BR1;
            end else begin
              // Not taken: step the PC past the unused address word.
              inc_PC     = 1'b1;
              state_next = S_FET1;
            end
          end
          default: state_next = S_HALT;
        endcase
      end

      S_EX1: begin
        sel_bus_1_mux = {1'b0, dest};
        sel_bus_2_mux = BUS2_ALU;
        load_Reg_Z    = 1'b1;
        load_r[dest]  = 1'b1;
        state_next    = S_FET1;
      end

      // Operand word in memory becomes the data address.
      S_RD1, S_WR1: begin
        sel_bus_2_mux = BUS2_MEM;
        load_Add_R    = 1'b1;
        inc_PC        = 1'b1;
        state_next    = (state == S_RD1) ? S_RD2 : S_WR2;
      end

      S_RD2: begin
        sel_bus_2_mux = BUS2_MEM;
        load_r[dest]  = 1'b1;
        state_next    = S_FET1;
      end

      S_WR2: begin
        sel_bus_1_mux = {1'b0, src};
        write         = 1'b1;
        state_next    = S_FET1;
      end

      S_BR1: begin
        sel_bus_2_mux = BUS2_MEM;
        load_Add_R    = 1'b1;
        state_next    = S_BR2;
      end

      S_BR2: begin
        sel_bus_2_mux = BUS2_MEM;
        load_PC       = 1'b1;
        state_next    = S_FET1;
      end

      S_HALT: state_next = S_HALT;

      // Unused encodings recover through IDLE.
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spm_control_unit.sv
// Scoreboard bench for spm_control_unit. The driver computes, per instruction,
// the full expected cycle-by-cycle sequence of {state, outputs} from the
// instruction table and pushes it into exp_q; the monitor pops and compares one
// entry on every falling edge while enabled.
module tb_spm_control_unit;
  import spm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic       zero = 1'b0;
  logic       load_R0, load_R1, load_R2, load_R3;
  logic       load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y, load_Reg_Z;
  logic [2:0] sel_bus_1_mux;
  logic [1:0] sel_bus_2_mux;
  logic       write;
  state_t     state;

  spm_control_unit #(.word_size(8)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
    .load_R0(load_R0), .load_R1(load_R1), .load_R2(load_R2), .load_R3(load_R3),
    .load_PC(load_PC), .inc_PC(inc_PC), .load_IR(load_IR),
    .load_Add_R(load_Add_R), .load_Reg_Y(load_Reg_Y), .load_Reg_Z(load_Reg_Z),
    .sel_bus_1_mux(sel_bus_1_mux), .sel_bus_2_mux(sel_bus_2_mux),
    .write(write), .state(state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Scoreboard storage and counters.
  logic [19:0] exp_q[$];
  logic [19:0] seq_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  // Vector layout: state, load_R3..R0, load_PC, inc_PC, load_IR, load_Add_R,
  // load_Reg_Y, load_Reg_Z, sel1, sel2, write.
  function automatic logic [19:0] mk(state_t st, logic [3:0] lr, logic pc,
                                     logic inc, logic ir, logic ar, logic y,
                                     logic z, logic [2:0] s1, logic [1:0] s2,
                                     logic w);
    return {st, lr, pc, inc, ir, ar, y, z, s1, s2, w};
  endfunction

  // Reference model: expected per-cycle sequence of one instruction, FET1 on.
  task automatic gen_seq(input logic [7:0] ins, input logic z);
    logic [3:0] op;
    logic [1:0] src, dest;
    logic [3:0] oh;
    op   = ins[7:4];
    src  = ins[3:2];
    dest = ins[1:0];
    oh   = 4'b0001 << dest;
    seq_q.delete();
    seq_q.push_back(mk(S_FET1, 4'h0, 0, 0, 0, 1, 0, 0, BUS1_PC, BUS2_BUS1, 0));
    seq_q.push_back(mk(S_FET2, 4'h0, 0, 1, 1, 0, 0, 0, 3'd0, BUS2_MEM, 0));
    if (op == OP_NOP) begin
      seq_q.push_back(mk(S_DEC, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    end else if (op == OP_ADD || op == OP_SUB || op == OP_AND) begin
      seq_q.push_back(mk(S_DEC, 4'h0, 0, 0, 0, 0, 1, 0, {1'b0, src}, 2'd0, 0));
      seq_q.push_back(mk(S_EX1, oh, 0, 0, 0, 0, 0, 1, {1'b0, dest}, BUS2_ALU, 0));
    end else if (op == OP_NOT) begin
      seq_q.push_back(mk(S_DEC, oh, 0, 0, 0, 0, 0, 1, {1'b0, src}, BUS2_ALU, 0));
    end else if (op == OP_RD) begin
      seq_q.push_back(mk(S_DEC, 4'h0, 0, 0, 0, 1, 0, 0, BUS1_PC, BUS2_BUS1, 0));
      seq_q.push_back(mk(S_RD1, 4'h0, 0, 1, 0, 1, 0, 0, 3'd0, BUS2_MEM, 0));
      seq_q.push_back(mk(S_RD2, oh, 0, 0, 0, 0, 0, 0, 3'd0, BUS2_MEM, 0));
    end else if (op == OP_WR) begin
      seq_q.push_back(mk(S_DEC, 4'h0, 0, 0, 0, 1, 0, 0, BUS1_PC, BUS2_BUS1, 0));
      seq_q.push_back(mk(S_WR1, 4'h0, 0, 1, 0, 1, 0, 0, 3'd0, BUS2_MEM, 0));
      seq_q.push_back(mk(S_WR2, 4'h0, 0, 0, 0, 0, 0, 0, {1'b0, src}, 2'd0, 1));
    end else if (op == OP_BR || (op == OP_BRZ && z)) begin
      seq_q.push_back(mk(S_DEC, 4'h0, 0, 0, 0, 1, 0, 0, BUS1_PC, BUS2_BUS1, 0));
      seq_q.push_back(mk(S_BR1, 4'h0, 0, 0, 0, 1, 0, 0, 3'd0, BUS2_MEM, 0));
      seq_q.push_back(mk(S_BR2, 4'h0, 1, 0, 0, 0, 0, 0, 3'd0, BUS2_MEM, 0));
    end else if (op == OP_BRZ) begin
      seq_q.push_back(mk(S_DEC, 4'h0, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    end else begin
      // HALT and illegal opcodes: DEC drives nothing; HALT cycles follow.
      seq_q.push_back(mk(S_DEC, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    end
  endtask

  // Driver tasks. All are entered and left 1 time unit after a rising edge.
  // Run cycles [0, ncyc) of the instruction's sequence; zero is random except
  // in the DEC cycle, where it takes the requested value.
  task automatic drive_cycles(input logic [7:0] ins, input logic z, input int ncyc);
    instruction = ins;
    for (int k = 0; k < ncyc; k++) begin
      exp_q.push_back(seq_q[k]);
      zero = (k == 2) ? z : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input logic [7:0] ins, input logic z);
    gen_seq(ins, z);
    drive_cycles(ins, z, seq_q.size());
  endtask

  // Reset: one cycle held low (checked asynchronously), then one IDLE cycle.
  task automatic do_reset();
    mon_en = 1'b1;
    rst = 1'b0;
    exp_q.push_back(mk(S_IDLE, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    instruction = 8'($urandom);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(mk(S_IDLE, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
    @(posedge clk); #1;
  endtask

  // Run k cycles of an instruction, then pull reset in the middle of it.
  task automatic run_abort(input logic [7:0] ins, input int k);
    gen_seq(ins, 1'b1);
    drive_cycles(ins, 1'b1, k);
    do_reset();
  endtask

  task automatic run_halt(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      exp_q.push_back(mk(S_HALT, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0));
      instruction = 8'($urandom);
      zero = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [7:0] rand_legal();
    logic [3:0] op;
    op = 4'($urandom_range(0, 8));
    return {op, 4'($urandom_range(0, 15))};
  endfunction

  // Monitor: the DUT presents a decoded output vector every cycle.
  logic [19:0] act_vec;
  assign act_vec = {state, load_R3, load_R2, load_R1, load_R0, load_PC, inc_PC,
                    load_IR, load_Add_R, load_Reg_Y, load_Reg_Z,
                    sel_bus_1_mux, sel_bus_2_mux, write};

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow t=%0t act=%h required=<none>", $time, act_vec);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if (act_vec !== e) begin
          errors++;
          $display("FAIL cycle t=%0t act=%h required=%h", $time, act_vec, e);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    rst = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Directed cases.
    run_instr(8'h00, 1'b0);    // NOP after reset
    run_abort(8'h00, 1);       // reset during FET2
    run_instr(8'h16, 1'b0);    // ADD R1,R2
    run_instr(8'h53, 1'b0);    // RD R3
    run_instr(8'h60, 1'b0);    // WR from R0
    run_instr(8'h80, 1'b0);    // BRZ not taken
    run_instr(8'h80, 1'b1);    // BRZ taken
    run_instr(8'h4B, 1'b1);    // NOT R2 -> R3
    run_instr(8'h7F, 1'b0);    // BR
    run_abort(8'h64, 4);       // reset during WR2: no write completes

    // Randomized legal instructions with occasional aborts.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] ins;
      ins = rand_legal();
      if ($urandom_range(0, 9) == 0)
        run_abort(ins, $urandom_range(1, 3));
      else
        run_instr(ins, 1'($urandom_range(0, 1)));
    end

    // Illegal opcode halts; only reset recovers.
    run_instr(8'hA0, 1'b0);
    run_halt(20);
    do_reset();
    run_instr(8'h00, 1'b0);

    // HALT and a random illegal/halt opcode.
    run_instr(8'hF5, 1'b1);
    run_halt(8);
    do_reset();
    run_instr({4'($urandom_range(9, 14)), 4'($urandom_range(0, 15))}, 1'b0);
    run_halt(5);
    do_reset();
    run_instr(8'h2D, 1'b0);

    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spm_control_unit.md
# spm_control_unit

Instruction-sequencing control unit for the 8-bit stored-program machine. It sits directly upstream of the address register and drives that register's `load` input. It also drives every other datapath load, mux-select and memory-write strobe. The unit walks fetch, decode and execute states for each instruction held in the instruction register, and stops in a halt state on HALT or an illegal opcode.

## Interface
- `word_size`, default 8: instruction width. Fields are opcode [7:4], src [3:2], dest [1:0].
- `clk`  input  1: single clock. All state changes happen on the rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `instruction`  input  word_size: current instruction register contents.
- `zero`  input  1: zero flag from the Z register.
- `load_R0`..`load_R3`  output  1 each: general register loads.
- `load_PC`  output  1: program counter load.
- `inc_PC`  output  1: program counter increment.
- `load_IR`  output  1: instruction register load.
- `load_Add_R`  output  1: address register load.
- `load_Reg_Y`  output  1: Y register load.
- `load_Reg_Z`  output  1: Z register load.
- `sel_bus_1_mux`  output  3: Bus1 source. R0=0, R1=1, R2=2, R3=3, PC=4.
- `sel_bus_2_mux`  output  2: Bus2 source. ALU=0, Bus1=1, MEM=2.
- `write`  output  1: memory write strobe.

## Operation
- State register: 12 states. It resets asynchronously to IDLE. Next state and all outputs are combinational functions of state, `instruction` and `zero`.
- Default for all outputs: 0 in every state, unless listed below.
- Opcodes:
  - NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8, HALT=F.
  - Opcodes 9–E are illegal.
- IDLE: all outputs 0. Next state FET1.
- FET1: sel1=PC, sel2=Bus1, load_Add_R. Next state FET2.
- FET2: sel2=MEM, load_IR, inc_PC. Next state DEC.
- DEC, by opcode:
  - NOP: next state FET1.
  - ADD/SUB/AND: sel1=src, load_Reg_Y. Next state EX1.
  - NOT: sel1=src, sel2=ALU, load_Reg_Z, load_R[dest]. Next state FET1.
  - RD/WR/BR: sel1=PC, sel2=Bus1, load_Add_R. Next state RD1, WR1 or BR1 respectively.
  - BRZ with zero=1: same outputs as BR. Next state BR1.
  - BRZ with zero=0: inc_PC, skipping the address word. Next state FET1.
  - HALT or illegal opcode: next state HALT.
- EX1: sel1=dest, sel2=ALU, load_Reg_Z, load_R[dest]. Next state FET1.
- RD1: sel2=MEM, load_Add_R, inc_PC. Next state RD2.
- RD2: sel2=MEM, load_R[dest]. Next state FET1.
- WR1: sel2=MEM, load_Add_R, inc_PC. Next state WR2.
- WR2: sel1=src, write. Next state FET1.
- BR1: sel2=MEM, load_Add_R. Next state BR2.
- BR2: sel2=MEM, load_PC. Next state FET1.
- HALT: all outputs 0. The unit stays in HALT until `rst` is asserted.
- At most one of load_R0..R3 is high in any cycle, and only the one selected by dest.
- `zero` is sampled only in DEC. It is ignored in every other state.

## Timing
- Reset: `rst`=0 forces state IDLE immediately and asynchronously, with every output 0. This holds even mid-instruction; no partial write completes. The first FET1 occurs one cycle after reset is released.
- Cycles per instruction, counted FET1 through the last execute state:
  - NOP: 3.
  - NOT: 3.
  - ADD/SUB/AND: 4.
  - RD/WR/BR: 5.
  - BRZ taken: 5.
  - BRZ not taken: 3.
- `write` is high for exactly one cycle per WR, in WR2.
- `load_Add_R` is asserted only in FET1, DEC (memory-class opcodes) and RD1/WR1/BR1.
- Outputs may glitch within a cycle. They are valid before the next rising edge.

## Structure
- Shared package `spm_pkg`:
  - state enumeration;
  - opcode constants;
  - Bus1/Bus2 select encodings;
  - instruction field positions.
- `spm_pkg` is reused by the datapath muxes and the ALU.
- Single module with no sub-module. It has one sequential process for the state register and one combinational process for next state and outputs.

## Test plan
- Reset, then release with instruction=0x00 (NOP) → states IDLE, FET1, FET2, DEC, FET1. Assert `rst` low during FET2 → state IDLE and all outputs 0 in the same cycle.
- ADD R1,R2 (0x16) → in DEC: sel1=1, load_Reg_Y. In EX1: sel1=2, sel2=0, load_Reg_Z, load_R2 only. Back to FET1 after 4 cycles.
- RD R3 (0x53) → load_Add_R in FET1, DEC and RD1. inc_PC in FET2 and RD1. In RD2: sel2=2, load_R3. Total 5 cycles.
- WR from R0 (0x60) → `write` high for exactly one cycle, in WR2, with sel1=0.
- BRZ (0x80) with zero=0 → inc_PC in DEC, next state FET1, no load_PC. With zero=1 → load_PC in BR2.
- Opcode 0xA0 → HALT after DEC. Outputs stay 0 for 20 cycles, and only reset recovers the unit.
